// File: rtl/eprisc_io_controller.sv
// epRISC peripheral-bus slave: byte-wide register file, 8N1 UART and 16 GPIO lines.
// The bus strobe and the serial input are asynchronous and are re-timed into the board clock domain.
module eprisc_io_controller #(
   parameter logic [7:0]  ID_VALUE = 8'hE5,
   parameter logic [15:0] BAUD_DIV = 16'd434,
   parameter logic [1:0]  SEL_CODE = 2'b01
) (
   input  logic        iBoardClock,
   input  logic        iBoardReset,
   input  logic        iBusClock,
   input  logic [1:0]  iBusSelect,
   input  logic [7:0]  iBusMOSI,
   output logic [7:0]  oBusMISO,
   output logic        oBusInterrupt,
   input  logic        iTTLSerialRX,
   output logic        oTTLSerialTX,
   inout  wire  [15:0] bGPIO
);

   typedef enum logic {BUS_CMD, BUS_DATA} busState_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rxState_t;

   busState_t   busState, busNext;
   rxState_t    rxState, rxNext;

   logic [1:0]  busClkSync, rxSync;
   logic        busClkPrev, rxPrev, rxLine;
   logic [15:0] gpioMeta, gpioIn;
   logic        byteEvent, selected;

   logic        cmdWrite, cmdWriteNext;
   logic [6:0]  cmdAddr, cmdAddrNext;
   logic [7:0]  misoNext, readValue;
   logic        wrEn, rdEn;

   logic [15:0] gpioOut, gpioDir, divisor, effDiv;
   logic [1:0]  irqEn;
   logic        rxValid, rxOverrun, txDone;
   logic [7:0]  rxData;

   logic        txBusy, txStart, txFinish;
   logic [9:0]  txShift;
   logic [15:0] txCnt;
   logic [3:0]  txBit;

   logic [15:0] rxCnt, rxCntNext;
   logic [2:0]  rxBit, rxBitNext;
   logic [7:0]  rxShift, rxShiftNext;
   logic        rxDone;

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         busClkSync <= 2'b00;
         rxSync     <= 2'b11;
         busClkPrev <= 1'b0;
         rxPrev     <= 1'b1;
         gpioMeta   <= '0;
         gpioIn     <= '0;
      end else begin
         busClkSync <= {busClkSync[0], iBusClock};
         rxSync     <= {rxSync[0], iTTLSerialRX};
         busClkPrev <= busClkSync[1];
         rxPrev     <= rxSync[1];
         gpioMeta   <= bGPIO;
         gpioIn     <= gpioMeta;
      end
   end

   assign rxLine    = rxSync[1];
   assign byteEvent = busClkSync[1] & ~busClkPrev;
   assign selected  = (iBusSelect == SEL_CODE);
   assign effDiv    = (divisor < 16'd4) ? 16'd4 : divisor;

   always_comb begin
      readValue = 8'h00;
      case (cmdAddr)
         7'h00:   readValue = ID_VALUE;
         7'h01:   readValue = {4'b0000, txDone, rxOverrun, txBusy, rxValid};
         7'h03:   readValue = rxData;
         7'h04:   readValue = gpioOut[7:0];
         7'h05:   readValue = gpioOut[15:8];
         7'h06:   readValue = gpioDir[7:0];
         7'h07:   readValue = gpioDir[15:8];
         7'h08:   readValue = gpioIn[7:0];
         7'h09:   readValue = gpioIn[15:8];
         7'h0A:   readValue = {6'b000000, irqEn};
         7'h0B:   readValue = divisor[7:0];
         7'h0C:   readValue = divisor[15:8];
         default: readValue = 8'h00;
      endcase
   end

   // MISO follows the addressed register live until the data byte arrives, so status reads are current.
   always_comb begin
      busNext      = busState;
      cmdWriteNext = cmdWrite;
      cmdAddrNext  = cmdAddr;
      misoNext     = 8'h00;
      wrEn         = 1'b0;
      rdEn         = 1'b0;
      if (!selected) begin
         busNext = BUS_CMD;
      end else begin
         case (busState)
            BUS_CMD: begin
               if (byteEvent) begin
                  cmdWriteNext = iBusMOSI[7];
                  cmdAddrNext  = iBusMOSI[6:0];
                  busNext      = BUS_DATA;
               end
            end
            BUS_DATA: begin
               if (byteEvent) begin
                  wrEn    = cmdWrite;
                  rdEn    = ~cmdWrite;
                  busNext = BUS_CMD;
               end else if (!cmdWrite) begin
                  misoNext = readValue;
               end
            end
            default: busNext = BUS_CMD;
         endcase
      end
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         busState <= BUS_CMD;
         cmdWrite <= 1'b0;
         cmdAddr  <= 7'h00;
         oBusMISO <= 8'h00;
      end else begin
         busState <= busNext;
         cmdWrite <= cmdWriteNext;
         cmdAddr  <= cmdAddrNext;
         oBusMISO <= misoNext;
      end
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         gpioOut <= '0;
         gpioDir <= '0;
         irqEn   <= 2'b00;
         divisor <= BAUD_DIV;
      end else if (wrEn) begin
         case (cmdAddr)
            7'h04:   gpioOut[7:0]  <= iBusMOSI;
            7'h05:   gpioOut[15:8] <= iBusMOSI;
            7'h06:   gpioDir[7:0]  <= iBusMOSI;
            7'h07:   gpioDir[15:8] <= iBusMOSI;
            7'h0A:   irqEn         <= iBusMOSI[1:0];
            7'h0B:   divisor[7:0]  <= iBusMOSI;
            7'h0C:   divisor[15:8] <= iBusMOSI;
            default: ;
         endcase
      end
   end

   // Hardware set is evaluated after clear-on-read so a coincident set wins.
   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         rxValid       <= 1'b0;
         rxOverrun     <= 1'b0;
         txDone        <= 1'b0;
         rxData        <= 8'h00;
         oBusInterrupt <= 1'b0;
      end else begin
         if (rdEn && cmdAddr == 7'h03) rxValid <= 1'b0;
         if (rdEn && cmdAddr == 7'h01) begin
            rxOverrun <= 1'b0;
            txDone    <= 1'b0;
         end
         if (rxDone) begin
            rxData  <= rxShiftNext;
            rxValid <= 1'b1;
            if (rxValid) rxOverrun <= 1'b1;
         end
         if (txFinish) txDone <= 1'b1;
         oBusInterrupt <= (rxValid & irqEn[0]) | (txDone & irqEn[1]);
      end
   end

   assign txStart  = wrEn && (cmdAddr == 7'h02) && !txBusy;
   assign txFinish = txBusy && (txCnt >= effDiv - 16'd1) && (txBit == 4'd9);

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         txBusy  <= 1'b0;
         txShift <= '1;
         txCnt   <= '0;
         txBit   <= 4'd0;
      end else if (txStart) begin
         txBusy  <= 1'b1;
         txShift <= {1'b1, iBusMOSI, 1'b0};
         txCnt   <= '0;
         txBit   <= 4'd0;
      end else if (txBusy) begin
         if (txCnt >= effDiv - 16'd1) begin
            txCnt <= '0;
            if (txBit == 4'd9) begin
               txBusy <= 1'b0;
            end else begin
               txShift <= {1'b1, txShift[9:1]};
               txBit   <= txBit + 4'd1;
            end
         end else begin
            txCnt <= txCnt + 16'd1;
         end
      end
   end

   assign oTTLSerialTX = txBusy ? txShift[0] : 1'b1;

   // Frame completes at the middle of data bit 7; the stop bit is not waited for.
   always_comb begin
      rxNext      = rxState;
      rxCntNext   = rxCnt + 16'd1;
      rxBitNext   = rxBit;
      rxShiftNext = rxShift;
      rxDone      = 1'b0;
      case (rxState)
         RX_IDLE: begin
            rxCntNext = '0;
            if (rxPrev && !rxLine) rxNext = RX_START;
         end
         RX_START: begin
            if (rxCnt >= (effDiv >> 1) - 16'd1) begin
               rxCntNext = '0;
               rxBitNext = 3'd0;
               rxNext    = rxLine ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rxCnt >= effDiv - 16'd1) begin
               rxCntNext   = '0;
               rxShiftNext = {rxLine, rxShift[7:1]};
               rxBitNext   = rxBit + 3'd1;
               if (rxBit == 3'd7) begin
                  rxDone = 1'b1;
                  rxNext = RX_IDLE;
               end
            end
         end
         default: rxNext = RX_IDLE;
      endcase
   end

   always_ff @(posedge iBoardClock or negedge iBoardReset) begin
      if (!iBoardReset) begin
         rxState <= RX_IDLE;
         rxCnt   <= '0;
         rxBit   <= 3'd0;
         rxShift <= 8'h00;
      end else begin
         rxState <= rxNext;
         rxCnt   <= rxCntNext;
         rxBit   <= rxBitNext;
         rxShift <= rxShiftNext;
      end
   end

   for (genvar i = 0; i < 16; i++) begin : gpioDrive
      assign bGPIO[i] = gpioDir[i] ? gpioOut[i] : 1'bz;
   end

endmodule

// File: tb/tb_eprisc_io_controller.sv
// Directed/randomized bench for eprisc_io_controller, checked against a register-level model of the controller.
module tb_eprisc_io_controller;

   localparam logic [1:0] SEL = 2'b01;

   logic        iBoardClock = 1'b0;
   logic        iBoardReset;
   logic        iBusClock;
   logic [1:0]  iBusSelect;
   logic [7:0]  iBusMOSI;
   logic [7:0]  oBusMISO;
   logic        oBusInterrupt;
   logic        iTTLSerialRX;
   logic        oTTLSerialTX;
   wire  [15:0] bGPIO;

   logic [15:0] tbVal, tbEn;

   logic [15:0] mGpioOut, mGpioDir, mDiv;
   logic [1:0]  mIrqEn;
   logic [7:0]  mRxData;
   logic        mRxValid, mRxOverrun, mTxDone;

   int compared;
   int mismatched;

   eprisc_io_controller dut (
      .iBoardClock  (iBoardClock),
      .iBoardReset  (iBoardReset),
      .iBusClock    (iBusClock),
      .iBusSelect   (iBusSelect),
      .iBusMOSI     (iBusMOSI),
      .oBusMISO     (oBusMISO),
      .oBusInterrupt(oBusInterrupt),
      .iTTLSerialRX (iTTLSerialRX),
      .oTTLSerialTX (oTTLSerialTX),
      .bGPIO        (bGPIO)
   );

   always #5 iBoardClock = ~iBoardClock;

   // External pin drivers stand in for whatever the board connects to input-configured lines.
   for (genvar g = 0; g < 16; g++) begin : tbPad
      assign bGPIO[g] = tbEn[g] ? tbVal[g] : 1'bz;
   end

   function automatic logic [7:0] randByte();
      logic [31:0] r;
      r = $urandom;
      return r[7:0];
   endfunction

   function automatic int effDiv();
      return (mDiv < 16'd4) ? 4 : int'(mDiv);
   endfunction

   function automatic logic expIrq();
      return (mRxValid & mIrqEn[0]) | (mTxDone & mIrqEn[1]);
   endfunction

   function automatic logic [7:0] modelRead(input logic [6:0] addr, input logic busy);
      logic [15:0] pins;
      pins = (mGpioDir & mGpioOut) | (~mGpioDir & tbVal);
      case (addr)
         7'h00:   return 8'hE5;
         7'h01:   return {4'b0000, mTxDone, mRxOverrun, busy, mRxValid};
         7'h03:   return mRxData;
         7'h04:   return mGpioOut[7:0];
         7'h05:   return mGpioOut[15:8];
         7'h06:   return mGpioDir[7:0];
         7'h07:   return mGpioDir[15:8];
         7'h08:   return pins[7:0];
         7'h09:   return pins[15:8];
         7'h0A:   return {6'b000000, mIrqEn};
         7'h0B:   return mDiv[7:0];
         7'h0C:   return mDiv[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One bus byte: MOSI changes while the strobe is low; MISO is sampled just before the rising edge.
   task automatic applyStimulus(input logic [7:0] b, output logic [7:0] misoSeen);
      iBusClock = 1'b0;
      iBusMOSI  = b;
      repeat (6) @(negedge iBoardClock);
      misoSeen  = oBusMISO;
      iBusClock = 1'b1;
      repeat (6) @(negedge iBoardClock);
   endtask

   task automatic regWrite(input logic [6:0] addr, input logic [7:0] data);
      logic [7:0] dummy;
      if (addr == 7'h06) tbEn[7:0]  = tbEn[7:0]  & ~data;
      if (addr == 7'h07) tbEn[15:8] = tbEn[15:8] & ~data;
      applyStimulus({1'b1, addr}, dummy);
      applyStimulus(data, dummy);
      case (addr)
         7'h04: mGpioOut[7:0]  = data;
         7'h05: mGpioOut[15:8] = data;
         7'h06: mGpioDir[7:0]  = data;
         7'h07: mGpioDir[15:8] = data;
         7'h0A: mIrqEn         = data[1:0];
         7'h0B: mDiv[7:0]      = data;
         7'h0C: mDiv[15:8]     = data;
         default: ;
      endcase
      tbEn = ~mGpioDir;
   endtask

   task automatic readCheck(input string tag, input logic [6:0] addr, input logic busy);
      logic [7:0] dummy, seen, expected;
      expected = modelRead(addr, busy);
      applyStimulus({1'b0, addr}, dummy);
      applyStimulus(8'h00, seen);
      checkOutput(tag, {8'h00, seen}, {8'h00, expected});
      if (addr == 7'h01) begin
         mRxOverrun = 1'b0;
         mTxDone    = 1'b0;
      end
      if (addr == 7'h03) mRxValid = 1'b0;
   endtask

   task automatic sendTx(input string tag, input logic [7:0] data);
      logic [7:0] dummy;
      logic [9:0] frame;
      int waitCnt;
      int eff;
      eff = effDiv();
      applyStimulus({1'b1, 7'h02}, dummy);
      iBusClock = 1'b0;
      iBusMOSI  = data;
      repeat (6) @(negedge iBoardClock);
      iBusClock = 1'b1;
      waitCnt = 0;
      while (oTTLSerialTX !== 1'b0 && waitCnt < 20) begin
         @(negedge iBoardClock);
         waitCnt++;
      end
      checkOutput({tag, "Start"}, {15'b0, waitCnt < 20}, 16'd1);
      if (waitCnt < 20) begin
         frame = '0;
         repeat (eff / 2) @(negedge iBoardClock);
         frame[0] = oTTLSerialTX;
         for (int j = 1; j < 10; j++) begin
            repeat (eff) @(negedge iBoardClock);
            frame[j] = oTTLSerialTX;
         end
         checkOutput(tag, {6'b0, frame}, {6'b0, 1'b1, data, 1'b0});
         repeat (eff / 2 + 4) @(negedge iBoardClock);
         mTxDone = 1'b1;
         checkOutput({tag, "Idle"}, {15'b0, oTTLSerialTX}, 16'd1);
      end
   endtask

   task automatic sendRx(input logic [7:0] data);
      logic [9:0] frame;
      int eff;
      eff   = effDiv();
      frame = {1'b1, data, 1'b0};
      for (int j = 0; j < 10; j++) begin
         iTTLSerialRX = frame[j];
         repeat (eff) @(negedge iBoardClock);
      end
      if (mRxValid) mRxOverrun = 1'b1;
      mRxData  = data;
      mRxValid = 1'b1;
   endtask

   initial begin
      logic [7:0] dummy, txA, rxA, rxB;
      compared     = 0;
      mismatched   = 0;
      iBoardReset  = 1'b0;
      iBusClock    = 1'b0;
      iBusSelect   = SEL;
      iBusMOSI     = 8'h00;
      iTTLSerialRX = 1'b1;
      tbVal        = {randByte(), randByte()};
      tbEn         = 16'hFFFF;
      mGpioOut     = '0;
      mGpioDir     = '0;
      mDiv         = 16'd434;
      mIrqEn       = 2'b00;
      mRxData      = 8'h00;
      mRxValid     = 1'b0;
      mRxOverrun   = 1'b0;
      mTxDone      = 1'b0;

      repeat (5) @(negedge iBoardClock);
      checkOutput("resetTx", {15'b0, oTTLSerialTX}, 16'd1);
      checkOutput("resetMiso", {8'h00, oBusMISO}, 16'h0000);
      checkOutput("resetIrq", {15'b0, oBusInterrupt}, 16'd0);
      iBoardReset = 1'b1;
      repeat (3) @(negedge iBoardClock);
      checkOutput("postResetTx", {15'b0, oTTLSerialTX}, 16'd1);

      readCheck("idRead", 7'h00, 1'b0);
      readCheck("gpioInLowHiZ", 7'h08, 1'b0);
      readCheck("gpioInHighHiZ", 7'h09, 1'b0);
      readCheck("divLowReset", 7'h0B, 1'b0);
      readCheck("divHighReset", 7'h0C, 1'b0);
      readCheck("statusReset", 7'h01, 1'b0);
      readCheck("unmapped", 7'h7F, 1'b0);
      regWrite(7'h00, 8'h12);
      readCheck("idReadOnly", 7'h00, 1'b0);

      regWrite(7'h06, 8'hFF);
      regWrite(7'h04, 8'hA5);
      readCheck("gpioPinLow", 7'h08, 1'b0);
      checkOutput("gpioPadLow", {8'h00, bGPIO[7:0]}, 16'h00A5);
      readCheck("gpioOutLow", 7'h04, 1'b0);
      regWrite(7'h05, randByte());
      readCheck("gpioHighUndriven", 7'h09, 1'b0);
      regWrite(7'h07, 8'hF0);
      readCheck("gpioHighMixed", 7'h09, 1'b0);
      readCheck("gpioDirHigh", 7'h07, 1'b0);

      applyStimulus(8'h84, dummy);
      iBusSelect = 2'b10;
      applyStimulus(randByte(), dummy);
      checkOutput("deselMiso", {8'h00, oBusMISO}, 16'h0000);
      iBusSelect = SEL;
      readCheck("deselAbort", 7'h04, 1'b0);

      regWrite(7'h0B, 8'h08);
      regWrite(7'h0C, 8'h00);
      sendTx("txFrame5A", 8'h5A);
      checkOutput("irqMaskedTx", {15'b0, oBusInterrupt}, {15'b0, expIrq()});
      readCheck("statusTxDone", 7'h01, 1'b0);
      readCheck("statusCleared", 7'h01, 1'b0);

      txA = randByte();
      regWrite(7'h02, txA);
      readCheck("statusBusy", 7'h01, 1'b1);
      regWrite(7'h02, ~txA);
      repeat (5 * 8) @(negedge iBoardClock);
      mTxDone = 1'b1;
      readCheck("statusAfterBusy", 7'h01, 1'b0);

      regWrite(7'h0A, 8'h02);
      sendTx("txFrameRand", randByte());
      repeat (3) @(negedge iBoardClock);
      checkOutput("irqTxDone", {15'b0, oBusInterrupt}, {15'b0, expIrq()});
      readCheck("statusIrqTx", 7'h01, 1'b0);
      repeat (3) @(negedge iBoardClock);
      checkOutput("irqTxCleared", {15'b0, oBusInterrupt}, {15'b0, expIrq()});

      regWrite(7'h0B, 8'h02);
      sendTx("txFrameDiv4", randByte());
      readCheck("statusDiv4", 7'h01, 1'b0);
      regWrite(7'h0B, 8'h08);

      regWrite(7'h0A, 8'h01);
      sendRx(8'h3C);
      repeat (3) @(negedge iBoardClock);
      checkOutput("irqRx", {15'b0, oBusInterrupt}, {15'b0, expIrq()});
      readCheck("rxData3C", 7'h03, 1'b0);
      repeat (3) @(negedge iBoardClock);
      checkOutput("irqRxCleared", {15'b0, oBusInterrupt}, {15'b0, expIrq()});

      iTTLSerialRX = 1'b0;
      @(negedge iBoardClock);
      iTTLSerialRX = 1'b1;
      repeat (16) @(negedge iBoardClock);
      readCheck("rxGlitch", 7'h01, 1'b0);

      rxA = randByte();
      rxB = randByte();
      sendRx(rxA);
      sendRx(rxB);
      readCheck("statusOverrun", 7'h01, 1'b0);
      readCheck("rxDataSecond", 7'h03, 1'b0);
      readCheck("statusAfterOverrun", 7'h01, 1'b0);

      for (int i = 0; i < 3; i++) begin
         sendRx(randByte());
         readCheck("rxDataRand", 7'h03, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no completion, expected finish before time limit");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
